// File: rtl/axis_slave.sv
// ---------------------------------------------------------------------------
// axis_slave
//   Receive side of the user-project AXI-Stream link. Upstream beats are
//   written into a small FIFO. The FIFO head is shown first-word-fall-through
//   to a backend consumer that uses a valid/ready handshake. Each stored
//   entry carries a start-of-frame flag. bk_done pulses once per consumed
//   frame. bk_nordy reports an upstream that a full FIFO has stalled for
//   too long.
//
// Ports
//   axi_aclk, axi_aresetn   clock, synchronous active-low reset
//   axis_t*                 upstream AXI-Stream slave interface
//   bk_valid/bk_ready       backend handshake on the FIFO head
//   bk_data/tstrb/tkeep/    head entry fields, zero when the FIFO is empty
//   user/tlast/sof
//   bk_clear                synchronous flush of FIFO, frame FSM and stall counter
//   bk_done                 pulse one cycle after a tlast entry is consumed
//   bk_nordy                upstream stalled for at least RDY_TIMEOUT cycles
// ---------------------------------------------------------------------------
module axis_slave #(
  parameter int FIFO_DEPTH  = 8,
  parameter int RDY_TIMEOUT = 5
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        axis_tvalid,
  input  logic [31:0] axis_tdata,
  input  logic [3:0]  axis_tstrb,
  input  logic [3:0]  axis_tkeep,
  input  logic [1:0]  axis_tuser,
  input  logic        axis_tlast,
  output logic        axis_tready,
  output logic        bk_valid,
  output logic [31:0] bk_data,
  output logic [3:0]  bk_tstrb,
  output logic [3:0]  bk_tkeep,
  output logic [1:0]  bk_user,
  output logic        bk_tlast,
  output logic        bk_sof,
  input  logic        bk_ready,
  input  logic        bk_clear,
  output logic        bk_done,
  output logic        bk_nordy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 44;

  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_FRAME = 1'b1
  } rx_state_t;

  // Entry layout: {sof, tlast, tuser, tkeep, tstrb, tdata}
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [7:0]    stall_r;
  logic [7:0]    stall_nxt_s;
  logic          done_r;
  rx_state_t     state_r;
  rx_state_t     state_nxt_s;

  logic          full_s;
  logic          empty_s;
  logic          tready_s;
  logic          push_s;
  logic          pop_s;
  logic          sof_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  assign full_s   = (count_r == CW'(FIFO_DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  // A flush cycle never accepts a beat, so nothing written that cycle can survive it.
  assign tready_s = !full_s && !bk_clear && axi_aresetn;
  assign push_s   = axis_tvalid && tready_s;
  // A pop during a flush is discarded together with the rest of the FIFO.
  assign pop_s    = !empty_s && bk_ready && !bk_clear;

  assign entry_s  = {sof_s, axis_tlast, axis_tuser, axis_tkeep, axis_tstrb, axis_tdata};
  assign head_s   = empty_s ? {EW{1'b0}} : mem_r[rd_ptr_r];

  assign axis_tready = tready_s;
  assign bk_valid    = !empty_s;
  assign bk_sof      = head_s[43];
  assign bk_tlast    = head_s[42];
  assign bk_user     = head_s[41:40];
  assign bk_tkeep    = head_s[39:36];
  assign bk_tstrb    = head_s[35:32];
  assign bk_data     = head_s[31:0];
  assign bk_done     = done_r;
  assign bk_nordy    = (stall_r >= 8'(RDY_TIMEOUT));

  // Frame FSM next state and start-of-frame flag for the beat being written
  always_comb begin
    state_nxt_s = state_r;
    sof_s       = 1'b0;
    case (state_r)
      RX_IDLE: begin
        sof_s = 1'b1;
        if (push_s && !axis_tlast) begin
          state_nxt_s = RX_FRAME;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_FRAME: begin
        sof_s = 1'b0;
        if (push_s && axis_tlast) begin
          state_nxt_s = RX_IDLE;
        end else begin
          state_nxt_s = RX_FRAME;
        end
      end
      default: begin
        sof_s       = 1'b1;
        state_nxt_s = RX_IDLE;
      end
    endcase
  end

  // Occupancy and stall-counter next values
  always_comb begin
    count_nxt_s = count_r;
    stall_nxt_s = stall_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (axis_tvalid && !tready_s) begin
      stall_nxt_s = (stall_r == 8'd255) ? stall_r : stall_r + 8'd1;
    end else begin
      stall_nxt_s = 8'd0;
    end
  end

  // Control state: pointers, occupancy, frame FSM, stall counter, done pulse
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      stall_r  <= 8'd0;
      done_r   <= 1'b0;
      state_r  <= RX_IDLE;
    end else if (bk_clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      stall_r  <= 8'd0;
      done_r   <= 1'b0;
      state_r  <= RX_IDLE;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      stall_r <= stall_nxt_s;
      done_r  <= pop_s && head_s[42];
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge axi_aclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

endmodule

// File: tb/tb_axis_slave.sv
module tb_axis_slave;

  logic        axi_aclk;
  logic        axi_aresetn;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb;
  logic [3:0]  axis_tkeep;
  logic [1:0]  axis_tuser;
  logic        axis_tlast;
  logic        axis_tready;
  logic        bk_valid;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb;
  logic [3:0]  bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_tlast;
  logic        bk_sof;
  logic        bk_ready;
  logic        bk_clear;
  logic        bk_done;
  logic        bk_nordy;

  int err_cnt;
  int chk_cnt;
  int n;

  axis_slave #(.FIFO_DEPTH(8), .RDY_TIMEOUT(5)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .axis_tvalid (axis_tvalid),
    .axis_tdata  (axis_tdata),
    .axis_tstrb  (axis_tstrb),
    .axis_tkeep  (axis_tkeep),
    .axis_tuser  (axis_tuser),
    .axis_tlast  (axis_tlast),
    .axis_tready (axis_tready),
    .bk_valid    (bk_valid),
    .bk_data     (bk_data),
    .bk_tstrb    (bk_tstrb),
    .bk_tkeep    (bk_tkeep),
    .bk_user     (bk_user),
    .bk_tlast    (bk_tlast),
    .bk_sof      (bk_sof),
    .bk_ready    (bk_ready),
    .bk_clear    (bk_clear),
    .bk_done     (bk_done),
    .bk_nordy    (bk_nordy)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick;
    @(posedge axi_aclk);
    #1;
  endtask

  // Sideband fields are derived from the data so they can be checked for passthrough.
  task automatic drive(input logic v, input logic [31:0] d, input logic last);
    axis_tvalid = v;
    axis_tdata  = d;
    axis_tstrb  = d[3:0];
    axis_tkeep  = ~d[3:0];
    axis_tuser  = d[1:0];
    axis_tlast  = last;
    #1;
  endtask

  initial begin
    err_cnt     = 0;
    chk_cnt     = 0;
    axi_aresetn = 1'b0;
    bk_ready    = 1'b0;
    bk_clear    = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    // Reset state
    tick; tick;
    chk("rst_tready", {31'd0, axis_tready}, 32'd0);
    chk("rst_valid",  {31'd0, bk_valid},    32'd0);
    chk("rst_data",   bk_data,              32'd0);
    chk("rst_nordy",  {31'd0, bk_nordy},    32'd0);
    chk("rst_done",   {31'd0, bk_done},     32'd0);
    axi_aresetn = 1'b1;
    #1;
    chk("post_rst_tready", {31'd0, axis_tready}, 32'd1);

    // 1: three-beat frame with the backend always ready
    bk_ready = 1'b1;
    drive(1'b1, 32'hA0, 1'b0);
    tick;
    drive(1'b1, 32'hA1, 1'b0);
    chk("t1_d0",     bk_data,              32'hA0);
    chk("t1_sof0",   {31'd0, bk_sof},      32'd1);
    chk("t1_strb0",  {28'd0, bk_tstrb},    32'h0);
    chk("t1_keep0",  {28'd0, bk_tkeep},    32'hF);
    chk("t1_rdy0",   {31'd0, axis_tready}, 32'd1);
    tick;
    drive(1'b1, 32'hA2, 1'b1);
    chk("t1_d1",     bk_data,              32'hA1);
    chk("t1_sof1",   {31'd0, bk_sof},      32'd0);
    chk("t1_user1",  {30'd0, bk_user},     32'd1);
    chk("t1_rdy1",   {31'd0, axis_tready}, 32'd1);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    chk("t1_d2",     bk_data,              32'hA2);
    chk("t1_last2",  {31'd0, bk_tlast},    32'd1);
    chk("t1_sof2",   {31'd0, bk_sof},      32'd0);
    chk("t1_done_early", {31'd0, bk_done}, 32'd0);
    tick;
    chk("t1_done",   {31'd0, bk_done},     32'd1);
    chk("t1_empty",  {31'd0, bk_valid},    32'd0);
    chk("t1_zero",   bk_data,              32'd0);
    tick;
    chk("t1_done_off", {31'd0, bk_done},   32'd0);

    // 2: fill with backend stalled, hold tvalid until bk_nordy, then drain
    bk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hB0 + i, 1'b0);
      chk("t2_fill_rdy", {31'd0, axis_tready}, 32'd1);
      tick;
    end
    drive(1'b1, 32'hB8, 1'b1);
    chk("t2_full_rdy", {31'd0, axis_tready}, 32'd0);
    for (int s = 1; s <= 5; s++) begin
      tick;
      chk("t2_nordy", {31'd0, bk_nordy}, (s >= 5) ? 32'd1 : 32'd0);
    end
    bk_ready = 1'b1;
    #1;
    chk("t2_h0",     bk_data,           32'hB0);
    chk("t2_sof0",   {31'd0, bk_sof},   32'd1);
    tick;
    chk("t2_rdy_back", {31'd0, axis_tready}, 32'd1);
    chk("t2_h1",     bk_data,           32'hB1);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    chk("t2_nordy_clr", {31'd0, bk_nordy}, 32'd0);
    chk("t2_h2",     bk_data,           32'hB2);
    for (int i = 3; i <= 8; i++) begin
      tick;
      chk("t2_order", bk_data, 32'hB0 + i);
      chk("t2_sof",   {31'd0, bk_sof}, 32'd0);
    end
    chk("t2_last",   {31'd0, bk_tlast}, 32'd1);
    tick;
    chk("t2_empty",  {31'd0, bk_valid}, 32'd0);
    chk("t2_done",   {31'd0, bk_done},  32'd1);

    // 3: full FIFO with simultaneous push and pop; pointers wrap
    bk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hC0 + i, 1'b0);
      tick;
    end
    bk_ready = 1'b1;
    n = 8;
    for (int k = 0; k <= 11; k++) begin
      drive(1'b1, 32'hC0 + n, (n == 18));
      chk("t3_rdy",  {31'd0, axis_tready}, (k != 0) ? 32'd1 : 32'd0);
      chk("t3_data", bk_data, 32'hC0 + k);
      tick;
      if (k != 0) n = n + 1;
    end
    drive(1'b0, 32'h0, 1'b0);
    for (int k = 12; k <= 18; k++) begin
      chk("t3_drain", bk_data, 32'hC0 + k);
      tick;
    end
    chk("t3_empty", {31'd0, bk_valid}, 32'd0);
    chk("t3_done",  {31'd0, bk_done},  32'd1);

    // 4: back-to-back single-beat frames
    tick;
    for (int i = 0; i <= 4; i++) begin
      drive((i < 4), 32'hD0 + i, 1'b1);
      if (i > 0) begin
        chk("t4_data", bk_data,            32'hD0 + i - 1);
        chk("t4_sof",  {31'd0, bk_sof},    32'd1);
        chk("t4_done", {31'd0, bk_done},   (i >= 2) ? 32'd1 : 32'd0);
      end
      tick;
    end
    chk("t4_done_last", {31'd0, bk_done},  32'd1);
    chk("t4_empty",     {31'd0, bk_valid}, 32'd0);

    // 5: flush with four entries stored mid-frame
    bk_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hE0 + i, 1'b0);
      tick;
    end
    bk_clear = 1'b1;
    bk_ready = 1'b1;
    drive(1'b1, 32'hE4, 1'b1);
    chk("t5_clr_rdy", {31'd0, axis_tready}, 32'd0);
    tick;
    bk_clear = 1'b0;
    bk_ready = 1'b0;
    #1;
    chk("t5_valid", {31'd0, bk_valid}, 32'd0);
    chk("t5_done",  {31'd0, bk_done},  32'd0);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    chk("t5_data",  bk_data,           32'hE4);
    chk("t5_sof",   {31'd0, bk_sof},   32'd1);
    bk_ready = 1'b1;
    tick; tick;

    // 6: one-cycle reset in the middle of a frame
    bk_ready = 1'b0;
    drive(1'b1, 32'hF0, 1'b0);
    tick;
    drive(1'b1, 32'hF1, 1'b0);
    tick;
    axi_aresetn = 1'b0;
    drive(1'b1, 32'hF2, 1'b0);
    chk("t6_rst_rdy", {31'd0, axis_tready}, 32'd0);
    tick;
    axi_aresetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    chk("t6_valid", {31'd0, bk_valid}, 32'd0);
    chk("t6_data",  bk_data,           32'd0);
    chk("t6_sof",   {31'd0, bk_sof},   32'd0);
    chk("t6_nordy", {31'd0, bk_nordy}, 32'd0);
    chk("t6_done",  {31'd0, bk_done},  32'd0);
    drive(1'b1, 32'h60, 1'b0);
    tick;
    drive(1'b1, 32'h61, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0);
    bk_ready = 1'b1;
    #1;
    chk("t6_g0",    bk_data,            32'h60);
    chk("t6_g0sof", {31'd0, bk_sof},    32'd1);
    tick;
    chk("t6_g1",    bk_data,            32'h61);
    chk("t6_g1sof", {31'd0, bk_sof},    32'd0);
    chk("t6_g1lst", {31'd0, bk_tlast},  32'd1);
    tick;
    chk("t6_done",  {31'd0, bk_done},   32'd1);
    chk("t6_empty", {31'd0, bk_valid},  32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
